// File: rtl/jt6295_mch_pkg.sv
// ============================================================================
// jt6295_mch_pkg: shared tables and saturation helper for the multi-channel
// OKI ADPCM decoder.                                              Rev 1.0
// ============================================================================
`default_nettype none

package jt6295_mch_pkg;

    localparam int IDX_MAX = 48;

    localparam logic [10:0] STEP_LUT [49] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
        11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
        11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
        11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
        11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
        11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
        11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
    };

    // Gain is in 1/32 units; indices above 8 mute the channel
    localparam logic signed [6:0] GAIN_LUT [16] = '{
        7'sd32, 7'sd22, 7'sd16, 7'sd11, 7'sd8, 7'sd6, 7'sd4, 7'sd3,
        7'sd2,  7'sd0,  7'sd0,  7'sd0,  7'sd0, 7'sd0, 7'sd0, 7'sd0
    };

    localparam logic [3:0] IDX_INC [4] = '{4'd2, 4'd4, 4'd6, 4'd8};

    function automatic logic signed [31:0] sat(input logic signed [31:0] value,
                                               input int                 width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jt6295_mch_state.sv
// ============================================================================
// jt6295_mch_state: per-channel {step_idx, acc} register file with an
// asynchronous read port and a cen-qualified write port.          Rev 1.0
// ============================================================================
`default_nettype none

module jt6295_mch_state #(
    parameter int CH = 4,
    parameter int AW = 12,
    parameter int SW = 2
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic                 cen,
    input  logic [SW-1:0]        rd_addr,
    output logic [5:0]           rd_idx,
    output logic signed [AW-1:0] rd_acc,
    input  logic                 we,
    input  logic [SW-1:0]        wr_addr,
    input  logic [5:0]           wr_idx,
    input  logic signed [AW-1:0] wr_acc
);

    logic [5:0]           r_idx [CH];
    logic signed [AW-1:0] r_acc [CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                r_idx[i] <= '0;
                r_acc[i] <= '0;
            end
        end else if (cen && we) begin
            r_idx[wr_addr] <= wr_idx;
            r_acc[wr_addr] <= wr_acc;
        end
    end

    assign rd_idx = r_idx[rd_addr];
    assign rd_acc = r_acc[rd_addr];

endmodule

`default_nettype wire

// File: rtl/jt6295_adpcm_mch.sv
// ============================================================================
// jt6295_adpcm_mch: time-multiplexed multi-channel OKI ADPCM decoder with
// per-channel key-on, pause, attenuation and a saturating mixer.  Rev 1.0
// ============================================================================
`default_nettype none

module jt6295_adpcm_mch #(
    parameter int CH   = 4,
    parameter int AW   = 12,
    parameter int OUTW = 14,
    parameter int SW   = $clog2(CH)
) (
    input  logic                   rst,
    input  logic                   clk,
    input  logic                   cen,
    output logic [SW-1:0]          slot,
    input  logic [3:0]             data,
    input  logic                   en,
    input  logic                   kon,
    input  logic [3:0]             att,
    output logic signed [AW-1:0]   ch_snd,
    output logic [SW-1:0]          ch_idx,
    output logic                   ch_valid,
    output logic signed [OUTW-1:0] mix,
    output logic                   mix_valid
);
    import jt6295_mch_pkg::*;

    localparam int            MW   = AW + SW;
    localparam logic [SW-1:0] LAST = SW'(CH - 1);

    // state file read/write
    logic [5:0]           w_rd_idx;
    logic signed [AW-1:0] w_rd_acc;
    logic                 w_we;

    // stage I
    logic                 r1_v;
    logic [SW-1:0]        r1_slot;
    logic [3:0]           r1_data;
    logic                 r1_en;
    logic                 r1_kon;
    logic [3:0]           r1_att;
    logic [5:0]           r1_idx;
    logic signed [AW-1:0] r1_acc;

    // stage II decode
    logic [5:0]           w_idx0;
    logic signed [AW-1:0] w_acc0;
    logic [10:0]          w_step;
    logic [11:0]          w_diff;
    logic signed [31:0]   w_sum;
    logic signed [AW-1:0] w_acc_new;
    logic signed [7:0]    w_inc;
    logic signed [7:0]    w_isum;
    logic [5:0]           w_idx_new;

    logic                 r2_v;
    logic [SW-1:0]        r2_slot;
    logic                 r2_act;
    logic [3:0]           r2_att;
    logic signed [AW-1:0] r2_acc;

    // stage III and mixer
    logic signed [31:0]   w_prod;
    logic signed [AW-1:0] w_snd;
    logic                 r3_v;
    logic signed [MW-1:0] r_sum;
    logic signed [MW-1:0] w_sum_mix;
    logic signed [OUTW-1:0] w_mix;

    jt6295_mch_state #(
        .CH (CH),
        .AW (AW),
        .SW (SW)
    ) u_state (
        .rst     (rst),
        .clk     (clk),
        .cen     (cen),
        .rd_addr (slot),
        .rd_idx  (w_rd_idx),
        .rd_acc  (w_rd_acc),
        .we      (w_we),
        .wr_addr (r1_slot),
        .wr_idx  (w_idx_new),
        .wr_acc  (w_acc_new)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot    <= '0;
            r1_v    <= 1'b0;
            r1_slot <= '0;
            r1_data <= '0;
            r1_en   <= 1'b0;
            r1_kon  <= 1'b0;
            r1_att  <= '0;
            r1_idx  <= '0;
            r1_acc  <= '0;
        end else if (cen) begin
            slot    <= (slot == LAST) ? '0 : slot + SW'(1);
            r1_v    <= 1'b1;
            r1_slot <= slot;
            r1_data <= data;
            r1_en   <= en;
            r1_kon  <= kon;
            r1_att  <= att;
            r1_idx  <= w_rd_idx;
            r1_acc  <= w_rd_acc;
        end
    end

    // Key-on decodes from a zeroed channel instead of the stored state
    always_comb begin
        w_idx0    = r1_kon ? 6'd0 : r1_idx;
        w_acc0    = r1_kon ? '0 : r1_acc;
        w_step    = STEP_LUT[w_idx0];
        w_diff    = 12'(w_step >> 3)
                  + (r1_data[2] ? 12'(w_step)      : 12'd0)
                  + (r1_data[1] ? 12'(w_step >> 1) : 12'd0)
                  + (r1_data[0] ? 12'(w_step >> 2) : 12'd0);
        w_sum     = r1_data[3] ? 32'(w_acc0) - $signed({20'd0, w_diff})
                               : 32'(w_acc0) + $signed({20'd0, w_diff});
        w_acc_new = AW'(sat(w_sum, AW));
        w_inc     = r1_data[2] ? $signed({4'd0, IDX_INC[r1_data[1:0]]}) : -8'sd1;
        w_isum    = $signed({2'd0, w_idx0}) + w_inc;
        w_idx_new = w_isum[5:0];
        if (w_isum < 8'sd0) begin
            w_idx_new = 6'd0;
        end else if (w_isum > 8'(IDX_MAX)) begin
            w_idx_new = 6'(IDX_MAX);
        end
    end

    // A paused channel keeps its state untouched
    assign w_we = r1_v & (r1_en | r1_kon);

    assign w_prod    = 32'(r2_acc) * 32'(GAIN_LUT[r2_att]);
    assign w_snd     = AW'(w_prod >>> 5);
    assign w_sum_mix = r_sum + MW'(ch_snd);
    assign w_mix     = OUTW'(sat(32'(w_sum_mix), OUTW));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_v      <= 1'b0;
            r2_slot   <= '0;
            r2_act    <= 1'b0;
            r2_att    <= '0;
            r2_acc    <= '0;
            r3_v      <= 1'b0;
            ch_snd    <= '0;
            ch_idx    <= '0;
            ch_valid  <= 1'b0;
            r_sum     <= '0;
            mix       <= '0;
            mix_valid <= 1'b0;
        end else begin
            ch_valid  <= cen & r2_v;
            mix_valid <= cen & r3_v & (ch_idx == LAST);
            if (cen) begin
                r2_v    <= r1_v;
                r2_slot <= r1_slot;
                r2_act  <= r1_en | r1_kon;
                r2_att  <= r1_att;
                r2_acc  <= w_acc_new;
                r3_v    <= r2_v;
                if (r2_v) begin
                    ch_snd <= r2_act ? w_snd : '0;
                    ch_idx <= r2_slot;
                end
                if (r3_v) begin
                    if (ch_idx == LAST) begin
                        mix   <= w_mix;
                        r_sum <= '0;
                    end else begin
                        r_sum <= w_sum_mix;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/jt6295_adpcm_mch.md
# jt6295_adpcm_mch

Time-multiplexed, parametrised multi-channel OKI ADPCM decoder with per-channel key-on, pause, attenuation and an integrated saturating mixer. One channel slot is processed per `cen`, with channel state held in an internal register file. It replaces the fixed 4-channel shift-register decoder used by the jt6295 top level, and serves any core needing 2–16 OKI-style ADPCM voices.

## Interface
Parameters:
- `CH`, 4: number of channels, legal range 2..16.
- `AW`, 12: signed accumulator and per-channel sample width.
- `OUTW`, 14: signed mixer output width, with `OUTW` ≥ `AW`.
- `SW`, `$clog2(CH)`: slot index width.

Ports (clock and reset first):
- `rst` in, 1: asynchronous, active-high reset.
- `clk` in, 1: clock.
- `cen` in, 1: clock enable. Each enabled edge advances one slot.
- `slot` out, `SW`: channel whose inputs are sampled at the next `cen` edge.
- `data` in, 4: ADPCM nibble for `slot`. Bit 3 is the sign; bits 2..0 are the magnitude.
- `en` in, 1: channel active. 0 means pause.
- `kon` in, 1: key-on. Restart the channel from zero state.
- `att` in, 4: attenuation index for `slot`.
- `ch_snd` out, `AW` signed: attenuated sample of one channel.
- `ch_idx` out, `SW`: channel that `ch_snd` belongs to.
- `ch_valid` out, 1: one-`clk` pulse when `ch_snd` updates.
- `mix` out, `OUTW` signed: saturated sum of all channels for one round.
- `mix_valid` out, 1: one-`clk` pulse when `mix` updates.

## Operation
- **Per-channel state:**
  - `step_idx`: 6 bits, range 0..48.
  - `acc`: `AW` bits, signed.
  - Both are 0 after reset.
- **Slot counter:**
  - Counts 0..CH-1 and wraps to 0.
  - Increments on every `cen` edge.
- **Step size:** `step = STEP_LUT[step_idx]`. The table has 49 entries (16, 17, 19 … 1411, 1552) and is 11 bits wide.
- **Difference:** `diff = (step>>3) + (d2?step:0) + (d1?step>>1:0) + (d0?step>>2:0)`. All terms are unsigned and truncated.
- **Accumulator update:** `acc' = sat(acc ± diff)`.
  - The sign comes from `data[3]`.
  - Saturation limits are −2^(AW−1) and 2^(AW−1)−1.
- **Index update:**
  - If `d2` = 1: add {2,4,6,8}, selected by `data[1:0]`.
  - If `d2` = 0: subtract 1.
  - Clamp the result to 0..48.
- **Key-on (`kon`=1):**
  - Decode this visit's nibble from `step_idx`=0 and `acc`=0.
  - Write the result back.
  - `kon` takes priority over `en`.
- **Pause (`en`=0, `kon`=0):**
  - State is held unchanged.
  - Channel output is 0.
- **Gain:**
  - `GAIN_LUT[att]` = 32, 22, 16, 11, 8, 6, 4, 3, 2 for `att` 0..8, and 0 for `att` 9..15.
  - `ch_snd = (acc' * gain) >>> 5`, an arithmetic shift (floor).
- **Mixer:**
  - Accumulates `ch_snd` for slots 0..CH-1 at full precision: `AW + SW` bits.
  - On slot CH-1: `mix ← sat_OUTW(sum)`, pulse `mix_valid`, clear the sum.
- **Hazards:** state written back for slot s is always visible at the next visit of s. `CH` ≥ 2 guarantees this.

## Timing
- **Reset values:** `slot`, `ch_snd`, `ch_idx`, `ch_valid`, `mix`, `mix_valid` are all 0. All state, pipeline registers and the mixer sum are 0. Pipeline valid flags are cleared.
- **Input sampling:** inputs for slot s are sampled at `cen` edge k, where k is the edge at which `slot`==s.
- **Pipeline stages:**
  - Stage I (edge k): register `data`, `en`, `kon`, `att` and state read for s.
  - Stage II (edge k+1): compute `acc'` and `step_idx'`, and write back to the state file.
  - Stage III (edge k+2): load `ch_snd` and `ch_idx`=s, and pulse `ch_valid`.
  - Mixer (edge k+3): load `mix` when s = CH-1.
- **Per-channel latency:** 3 `cen` edges. `ch_valid` and `mix_valid` are high exactly one `clk` after the loading edge, including when `cen` is asserted continuously.
- **First outputs after reset:**
  - First `ch_valid` follows edge 2.
  - First `mix_valid` follows edge CH+2.
  - No partial round is ever reported.
- **Clock gating:** with `cen` low, nothing advances and pulses do not repeat.
- **Reset mid-round:**
  - All outputs clear immediately.
  - In-flight samples are discarded.
  - The slot restarts at 0.

## Structure
- **Package `jt6295_mch_pkg`:**
  - `STEP_LUT` (49×11).
  - `GAIN_LUT` (16×7 signed).
  - The index increment table.
  - Function `sat(value, width)`.
- **Sub-module `jt6295_mch_state`:**
  - CH-entry register file of {`step_idx`, `acc`}.
  - One asynchronous read port and one write port enabled by `cen`.
  - Asynchronous reset clears it.
- **Top level:** contains the slot counter, the stage I–III pipeline and the mixer.

## Test plan
1. **Basic decode.** `CH`=4, `en`=1, `att`=0, `data`=0 on all slots for one round.
   - Each `ch_snd` = 2 (`diff` = 16>>3), and `step_idx` stays at 0.
   - `mix` = 8, with the first `mix_valid` after edge 6.
2. **Index growth.** Slot 1, `data`=4'b0111 on two visits.
   - `acc` = 30, then 93.
   - `step_idx` = 8, then 16.
3. **Saturation.**
   - Repeated 0111 drives `acc` to 2047 and `step_idx` to 48.
   - Then repeated 1111 drives `acc` to −2048 with no wrap.
   - With `CH`=4 and all slots at 2047, `mix` = 8188 (fits in 14 bits). With `OUTW`=13, `mix` = 4095.
4. **Attenuation.** `acc`=93:
   - `att`=1 gives `ch_snd` = 63.
   - `att`=9 gives 0.
   - `acc`=−93 with `att`=1 gives −64.
5. **Pause and key-on.**
   - Slot 2 with `en`=0 for one visit outputs 0. The next visit continues from the held `acc`.
   - `kon`=1 with `data`=0 gives `acc` = 2 and `step_idx` = 0 regardless of prior state.
6. **Reset mid-round.** Assert `rst` during slot 2.
   - All outputs read 0 immediately and `slot` = 0.
   - The next `mix_valid` occurs only after edge CH+2 following release.
